dct_stream_ctrl: RTL and testbench

// - Sequencer/flow controller for the bit-serial distributed-arithmetic DCT core (8-bit in, 12-bit out, one sample per enabled cycle).
// - Accepts pixels over valid/ready and drives the core's enable and data input.
// - Tags real vs. filler samples through the core's fixed latency, and delivers coefficients over valid/ready with block framing.
// - Sits between the level-shift/pixel source and the quantiser in the JPEG encoder.

---
 rtl/jpeg_pkg.sv | 20 ++
 rtl/dct_out_fifo.sv | 70 +++++++
 rtl/dct_stream_ctrl.sv | 199 +++++++++++++++++++
 tb/tb_dct_stream_ctrl.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/jpeg_pkg.sv
// Shared JPEG encoder constants, DCT sequencer state encoding and pixel helpers.
package jpeg_pkg;

  localparam int DCT_IN_W  = 8;
  localparam int DCT_OUT_W = 12;
  localparam int BLK_SIZE  = 64;
  localparam int DCT_LAT   = 21;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } dct_state_e;

  // Unsigned pixel to two's-complement sample centred on zero.
  function automatic logic [DCT_IN_W-1:0] level_shift(input logic [DCT_IN_W-1:0] pix);
    return pix ^ 8'h80;
  endfunction

endpackage

// File: rtl/dct_out_fifo.sv
// Synchronous coefficient FIFO with occupancy count; head word is zero while empty.
module dct_out_fifo #(
  parameter int W     = 14,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     wr_en,
  input  logic [W-1:0]             wr_data,
  input  logic                     rd_en,
  output logic [W-1:0]             rd_data,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  mem_r [DEPTH];
  logic [AW-1:0] wr_ptr_r;
  logic [AW-1:0] rd_ptr_r;
  logic [CW-1:0] count_r;
  logic          full_s;
  logic          do_wr_s;
  logic          do_rd_s;

  assign full_s  = (count_r == CW'(DEPTH));
  assign empty   = (count_r == {CW{1'b0}});
  assign do_rd_s = rd_en & ~empty;
  assign do_wr_s = wr_en & (~full_s | do_rd_s);
  assign count   = count_r;

  // Storage array
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= {W{1'b0}};
      end
    end else if (do_wr_s) begin
      mem_r[wr_ptr_r] <= wr_data;
    end
  end

  // Pointers and occupancy; simultaneous push and pop leave the count unchanged
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else begin
      if (do_wr_s) wr_ptr_r <= wr_ptr_r + AW'(1);
      if (do_rd_s) rd_ptr_r <= rd_ptr_r + AW'(1);
      case ({do_wr_s, do_rd_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Head word, forced to zero when nothing is stored
  always_comb begin
    if (empty) begin
      rd_data = {W{1'b0}};
    end else begin
      rd_data = mem_r[rd_ptr_r];
    end
  end

endmodule

// File: rtl/dct_stream_ctrl.sv
// Sequencer and flow controller for the bit-serial DA DCT core with block-framed output.
// Build macro DCT_LEVEL_SHIFT_EN: pixels are level-shifted (xor 8'h80) before entering the core.
module dct_stream_ctrl
  import jpeg_pkg::*;
#(
  parameter int LAT       = DCT_LAT,
  parameter int OUT_DEPTH = 16,
  parameter int BLK       = BLK_SIZE
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [DCT_IN_W-1:0]  in_data,
  output logic                 dct_en,
  output logic [DCT_IN_W-1:0]  dct_data,
  input  logic [DCT_OUT_W-1:0] dct_out,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [DCT_OUT_W-1:0] out_data,
  output logic                 out_sob,
  output logic                 out_eob,
  output logic                 busy,
  output logic [15:0]          blk_cnt
);

  localparam int PIX_W  = $clog2(BLK);
  localparam int FL_W   = $clog2(LAT);
  localparam int CNT_W  = $clog2(OUT_DEPTH) + 1;
  localparam int FIFO_W = DCT_OUT_W + 2;

  localparam logic [1:0] S_IDLE  = 2'(IDLE);
  localparam logic [1:0] S_RUN   = 2'(RUN);
  localparam logic [1:0] S_FLUSH = 2'(FLUSH);

  logic [1:0]          state_r;
  logic [1:0]          state_nxt_s;
  logic                live_r;
  logic [PIX_W-1:0]    pix_cnt_r;
  logic [FL_W-1:0]     flush_cnt_r;
  logic [LAT-1:0]      tag_r;
  logic                en_d_r;
  logic [PIX_W-1:0]    coef_cnt_r;
  logic [15:0]         blk_cnt_r;

  logic [CNT_W-1:0]    fifo_cnt_s;
  logic                fifo_empty_s;
  logic [CNT_W:0]      occ_s;
  logic                space_s;
  logic                accept_s;
  logic                in_ready_s;
  logic                dct_en_s;
  logic [DCT_IN_W-1:0] dct_data_s;
  logic [DCT_IN_W-1:0] pix_s;
  logic                push_s;
  logic                pop_s;
  logic [FIFO_W-1:0]   fifo_wdata_s;
  logic [FIFO_W-1:0]   fifo_rdata_s;

`ifdef DCT_LEVEL_SHIFT_EN
  assign pix_s = level_shift(in_data);
`else
  assign pix_s = in_data;
`endif

  // A push already in flight (en_d) must be counted, or the FIFO could overflow by one.
  assign occ_s   = {1'b0, fifo_cnt_s} + {{CNT_W{1'b0}}, en_d_r};
  assign space_s = (occ_s < (CNT_W + 1)'(OUT_DEPTH));

  // Handshake, core enable and next-state decode
  always_comb begin
    state_nxt_s = state_r;
    in_ready_s  = 1'b0;
    accept_s    = 1'b0;
    dct_en_s    = 1'b0;
    dct_data_s  = {DCT_IN_W{1'b0}};
    case (state_r)
      S_IDLE, S_RUN: begin
        in_ready_s = space_s & live_r;
        accept_s   = in_valid & in_ready_s;
        dct_en_s   = accept_s;
        if (live_r) begin
          dct_data_s = pix_s;
        end else begin
          dct_data_s = {DCT_IN_W{1'b0}};
        end
        if (state_r == S_IDLE) begin
          if (accept_s) begin
            state_nxt_s = S_RUN;
          end else begin
            state_nxt_s = S_IDLE;
          end
        end else if ((pix_cnt_r == {PIX_W{1'b0}}) && !in_valid) begin
          state_nxt_s = S_FLUSH;
        end else begin
          state_nxt_s = S_RUN;
        end
      end
      S_FLUSH: begin
        dct_en_s = space_s;
        if (space_s && (flush_cnt_r == FL_W'(LAT - 1))) begin
          state_nxt_s = S_IDLE;
        end else begin
          state_nxt_s = S_FLUSH;
        end
      end
      default: begin
        state_nxt_s = S_IDLE;
      end
    endcase
  end

  // State register and post-reset enable qualifier
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= S_IDLE;
      live_r  <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      live_r  <= 1'b1;
    end
  end

  // Pixel position within the input block and filler count during FLUSH
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pix_cnt_r   <= {PIX_W{1'b0}};
      flush_cnt_r <= {FL_W{1'b0}};
    end else begin
      if (accept_s) begin
        if (pix_cnt_r == PIX_W'(BLK - 1)) pix_cnt_r <= {PIX_W{1'b0}};
        else                              pix_cnt_r <= pix_cnt_r + PIX_W'(1);
      end
      if ((state_r == S_FLUSH) && dct_en_s) begin
        if (flush_cnt_r == FL_W'(LAT - 1)) flush_cnt_r <= {FL_W{1'b0}};
        else                               flush_cnt_r <= flush_cnt_r + FL_W'(1);
      end
    end
  end

  // Real/filler tag line tracking samples through the core pipeline
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tag_r  <= {LAT{1'b0}};
      en_d_r <= 1'b0;
    end else begin
      en_d_r <= dct_en_s;
      if (dct_en_s) begin
        tag_r <= {tag_r[LAT-2:0], accept_s};
      end
    end
  end

  // Core output is valid the cycle after the enable that moved a real tag to the line end.
  assign push_s       = en_d_r & tag_r[LAT-1];
  assign pop_s        = ~fifo_empty_s & out_ready;
  assign fifo_wdata_s = {(coef_cnt_r == {PIX_W{1'b0}}), (coef_cnt_r == PIX_W'(BLK - 1)), dct_out};

  // Output coefficient position and completed-block counter
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      coef_cnt_r <= {PIX_W{1'b0}};
      blk_cnt_r  <= 16'd0;
    end else begin
      if (push_s) begin
        if (coef_cnt_r == PIX_W'(BLK - 1)) coef_cnt_r <= {PIX_W{1'b0}};
        else                               coef_cnt_r <= coef_cnt_r + PIX_W'(1);
      end
      if (pop_s && fifo_rdata_s[DCT_OUT_W]) begin
        blk_cnt_r <= blk_cnt_r + 16'd1;
      end
    end
  end

  dct_out_fifo #(
    .W     (FIFO_W),
    .DEPTH (OUT_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .wr_en   (push_s),
    .wr_data (fifo_wdata_s),
    .rd_en   (pop_s),
    .rd_data (fifo_rdata_s),
    .empty   (fifo_empty_s),
    .count   (fifo_cnt_s)
  );

  assign in_ready  = in_ready_s;
  assign dct_en    = dct_en_s;
  assign dct_data  = dct_data_s;
  assign out_valid = ~fifo_empty_s;
  assign out_data  = fifo_rdata_s[DCT_OUT_W-1:0];
  assign out_eob   = fifo_rdata_s[DCT_OUT_W];
  assign out_sob   = fifo_rdata_s[DCT_OUT_W+1];
  assign busy      = (state_r != S_IDLE) | ~fifo_empty_s;
  assign blk_cnt   = blk_cnt_r;

endmodule

// File: tb/tb_dct_stream_ctrl.sv
// Directed bench for dct_stream_ctrl with a fixed-latency core stub and output scoreboard.
module tb_dct_stream_ctrl;

  localparam int LAT = 21;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_data;
  logic        dct_en;
  logic [7:0]  dct_data;
  logic [11:0] dct_out;
  logic        out_valid;
  logic        out_ready;
  logic [11:0] out_data;
  logic        out_sob;
  logic        out_eob;
  logic        busy;
  logic [15:0] blk_cnt;

  dct_stream_ctrl dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .dct_en    (dct_en),
    .dct_data  (dct_data),
    .dct_out   (dct_out),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_sob   (out_sob),
    .out_eob   (out_eob),
    .busy      (busy),
    .blk_cnt   (blk_cnt)
  );

  always #5 clk = ~clk;

  // Core stub: LAT-stage pipeline advancing only on enable
  logic [7:0] stub_pipe [LAT];
  initial for (int i = 0; i < LAT; i++) stub_pipe[i] = 8'd0;
  always @(posedge clk) begin
    if (dct_en) begin
      stub_pipe[0] <= dct_data;
      for (int i = 1; i < LAT; i++) stub_pipe[i] <= stub_pipe[i-1];
    end
  end
  assign dct_out = {4'h0, stub_pipe[LAT-1]};

  int n_chk  = 0;
  int n_pass = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end else begin
      n_pass++;
    end
  endtask

  logic [13:0] got_q[$];
  logic [13:0] exp_q[$];
  logic        win = 1'b0;
  int          en_cnt, fill_win, fill_all, rdy_low, stab_err, ovf_cnt;
  logic        hold_prev = 1'b0;
  logic [13:0] prev_val  = 14'd0;

  // Output capture, hold-stability, overflow and enable accounting
  always @(negedge clk) begin
    if (reset_n) begin
      if (out_valid && out_ready) got_q.push_back({out_sob, out_eob, out_data});
      if (hold_prev && ({out_sob, out_eob, out_data} !== prev_val)) stab_err++;
      hold_prev = out_valid && !out_ready;
      prev_val  = {out_sob, out_eob, out_data};
      if (dut.u_fifo.wr_en && dut.u_fifo.full_s && !dut.u_fifo.rd_en) ovf_cnt++;
      if (dct_en && !(in_valid && in_ready)) fill_all++;
      if (win) begin
        if (dct_en) en_cnt++;
        if (dct_en && !(in_valid && in_ready)) fill_win++;
        if (in_valid && !in_ready) rdy_low++;
      end
    end else begin
      hold_prev = 1'b0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [11:0] model(input logic [7:0] d);
`ifdef DCT_LEVEL_SHIFT_EN
    return {4'h0, d ^ 8'h80};
`else
    return {4'h0, d};
`endif
  endfunction

  function automatic logic [7:0] pix(input int kind, input int i);
    case (kind)
      0:       return 8'(i);
      1:       return 8'hC8;
      2:       return 8'((i * 3 + 7) & 255);
      default: return 8'(i) ^ 8'h5A;
    endcase
  endfunction

  task automatic drive_pixel(input logic [7:0] d);
    logic acc;
    acc      = 1'b0;
    in_valid = 1'b1;
    in_data  = d;
    for (int k = 0; k < 1000 && !acc; k++) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
    end
    if (!acc) chk("accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic send_block(input int kind, input int npix, input bit gaps);
    for (int i = 0; i < npix; i++) begin
      exp_q.push_back({(i == 0), (i == 63), model(pix(kind, i))});
      drive_pixel(pix(kind, i));
      if (gaps && (i % 5 == 4)) begin
        in_valid = 1'b0;
        repeat (3) tick();
      end
    end
  endtask

  task automatic wait_idle();
    bit done;
    done = 1'b0;
    for (int k = 0; k < 3000 && !done; k++) begin
      @(negedge clk);
      done = !busy;
    end
    if (!done) chk("idle_timeout", 32'd0, 32'd1);
    repeat (10) tick();
  endtask

  task automatic compare_q(input string tag);
    int n;
    chk({tag, "_len"}, 32'(got_q.size()), 32'(exp_q.size()));
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) chk({tag, "_word"}, 32'(got_q[i]), 32'(exp_q[i]));
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic clear_counts();
    en_cnt = 0; fill_win = 0; fill_all = 0; rdy_low = 0;
  endtask

  initial begin
    reset_n = 1'b0; in_valid = 1'b0; in_data = 8'd0; out_ready = 1'b1;
    stab_err = 0; ovf_cnt = 0;
    clear_counts();
    repeat (3) tick();
    @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_dct_en", 32'(dct_en), 32'd0);
    chk("rst_dct_data", 32'(dct_data), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_sob_eob", 32'({out_sob, out_eob}), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_blk_cnt", 32'(blk_cnt), 32'd0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    repeat (2) tick();

    // Single block 0..63 followed by FLUSH
    clear_counts();
    win = 1'b1; send_block(0, 64, 1'b0); win = 1'b0;
    in_valid = 1'b0;
    wait_idle();
    compare_q("blk1");
    chk("blk1_blk_cnt", 32'(blk_cnt), 32'd1);
    chk("blk1_busy", 32'(busy), 32'd0);
    chk("blk1_en_cnt", 32'(en_cnt), 32'd64);
    chk("blk1_flush_len", 32'(fill_all), 32'(LAT));

    // Constant 8'hC8 block (12'h048 with level shift, 12'h0C8 without)
    send_block(1, 64, 1'b0);
    in_valid = 1'b0;
    wait_idle();
    compare_q("const");
    chk("const_blk_cnt", 32'(blk_cnt), 32'd2);

    // Two back-to-back blocks: no FLUSH, no bubble
    clear_counts();
    win = 1'b1; send_block(2, 64, 1'b0); send_block(3, 64, 1'b0); win = 1'b0;
    in_valid = 1'b0;
    wait_idle();
    compare_q("b2b");
    chk("b2b_blk_cnt", 32'(blk_cnt), 32'd4);
    chk("b2b_en_cnt", 32'(en_cnt), 32'd128);
    chk("b2b_no_filler", 32'(fill_win), 32'd0);
    chk("b2b_ready_low", 32'(rdy_low), 32'd0);
    chk("b2b_flush_len", 32'(fill_all), 32'(LAT));

    // Downstream stall of 100 cycles mid-block
    fork
      begin
        send_block(0, 64, 1'b0);
        in_valid = 1'b0;
      end
      begin
        repeat (10) tick();
        out_ready = 1'b0;
        repeat (100) tick();
        @(negedge clk);
        chk("stall_dct_en", 32'(dct_en), 32'd0);
        chk("stall_in_ready", 32'(in_ready), 32'd0);
        chk("stall_out_valid", 32'(out_valid), 32'd1);
        @(posedge clk); #1;
        out_ready = 1'b1;
      end
    join
    wait_idle();
    compare_q("stall");
    chk("stall_blk_cnt", 32'(blk_cnt), 32'd5);
    chk("stall_hold_stable", 32'(stab_err), 32'd0);

    // Input gaps of 3 cycles every 5 pixels
    clear_counts();
    win = 1'b1; send_block(0, 64, 1'b1); win = 1'b0;
    in_valid = 1'b0;
    wait_idle();
    compare_q("gaps");
    chk("gaps_en_cnt", 32'(en_cnt), 32'd64);
    chk("gaps_no_filler", 32'(fill_win), 32'd0);
    chk("gaps_blk_cnt", 32'(blk_cnt), 32'd6);

    // Reset at pixel 30, then a clean block
    send_block(0, 30, 1'b0);
    in_valid = 1'b0;
    reset_n  = 1'b0;
    @(negedge clk);
    chk("mrst_out_valid", 32'(out_valid), 32'd0);
    chk("mrst_busy", 32'(busy), 32'd0);
    chk("mrst_blk_cnt", 32'(blk_cnt), 32'd0);
    chk("mrst_dct_en", 32'(dct_en), 32'd0);
    chk("mrst_in_ready", 32'(in_ready), 32'd0);
    got_q.delete();
    exp_q.delete();
    @(posedge clk); #1;
    reset_n = 1'b1;
    repeat (2) tick();
    send_block(0, 64, 1'b0);
    in_valid = 1'b0;
    wait_idle();
    repeat (30) tick();
    compare_q("mrst");
    chk("mrst_blk_after", 32'(blk_cnt), 32'd1);
    chk("no_overflow", 32'(ovf_cnt), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
